// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo-MODULUS up/down counter with load, cascade tc, wrap pulse and sticky load error.
// Define UDCNT_SAT_EN to saturate at 0 / MODULUS-1 instead of wrapping.
module updown_counter_mod #(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 16,
   parameter int RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);
   localparam int MAX_I = MODULUS - 1;
   localparam logic [WIDTH:0] MAX = MAX_I[WIDTH:0];
   localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];
`ifdef UDCNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   // one extra bit keeps MODULUS = 2^WIDTH representable in compares
   logic [WIDTH:0] qx, lx, nxt;
   logic unused_msb;
   assign qx = {1'b0, q};
   assign lx = {1'b0, load_val};
   assign tc = en & ~load & (up_dn ? qx == MAX : qx == '0);
   assign nxt = load ? (lx <= MAX ? lx : MAX) :
                tc   ? (SAT ? qx : (up_dn ? '0 : MAX)) :
                en   ? (up_dn ? qx + 1'b1 : qx - 1'b1) :
                       qx;
   assign unused_msb = nxt[WIDTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= RST_Q;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= nxt[WIDTH-1:0];
         wrap     <= tc & ~SAT;
         load_err <= load_err | (load & (lx > MAX));
      end
   end
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: scoreboard bench driving a decimal (4/10/0) and a full-range (3/8/5) counter, plus a two-digit cascade.
module tb_updown_counter_mod;
   logic clk = 1'b0;
   always #5 clk = ~clk;
`ifdef UDCNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic rst, en, up_dn, load;
   logic [3:0] lv;
   logic [3:0] qa;
   logic [2:0] qb;
   logic tca, tcb, wa, wb, ea, eb;
   logic c_rst, c_en;
   logic [3:0] lo_q, hi_q;
   logic lo_tc, hi_tc, lo_w, hi_w, lo_e, hi_e;

   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv),
      .q(qa), .tc(tca), .wrap(wa), .load_err(ea));
   updown_counter_mod #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(5)) dut_b (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[2:0]),
      .q(qb), .tc(tcb), .wrap(wb), .load_err(eb));
   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) c_lo (
      .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .q(lo_q), .tc(lo_tc), .wrap(lo_w), .load_err(lo_e));
   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) c_hi (
      .clk(clk), .rst(c_rst), .en(lo_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .q(hi_q), .tc(hi_tc), .wrap(hi_w), .load_err(hi_e));

   typedef struct {int q[2]; bit w[2]; bit e[2];} st_t;
   st_t sq[$];
   logic [1:0] tq[$];
   int tests = 0, fails = 0;
   int mod_k[2] = '{10, 8};
   int rv_k[2] = '{0, 5};
   int mq[2];
   bit me[2];
   bit mvalid = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: plain modular arithmetic on the count
   task automatic cyc(input bit r, input bit l, input int v, input bit e, input bit u);
      st_t s;
      logic [1:0] t;
      int m, val;
      @(negedge clk);
      rst = r; load = l; lv = 4'(v); en = e; up_dn = u;
      for (int k = 0; k < 2; k++) begin
         m = mod_k[k];
         val = k == 0 ? v % 16 : v % 8;
         t[k] = e && !l && (u ? mq[k] == m - 1 : mq[k] == 0);
         s.w[k] = 1'b0;
         if (r) begin
            mq[k] = rv_k[k];
            me[k] = 1'b0;
         end else if (l) begin
            if (val < m) mq[k] = val;
            else begin
               mq[k] = m - 1;
               me[k] = 1'b1;
            end
         end else if (e) begin
            if (u) begin
               s.w[k] = mq[k] + 1 >= m;
               mq[k] = (SAT && s.w[k]) ? m - 1 : (mq[k] + 1) % m;
            end else begin
               s.w[k] = mq[k] == 0;
               mq[k] = (SAT && s.w[k]) ? 0 : (mq[k] + m - 1) % m;
            end
            if (SAT) s.w[k] = 1'b0;
         end
         s.q[k] = mq[k];
         s.e[k] = me[k];
      end
      if (mvalid) tq.push_back(t);
      mvalid = mvalid | r;
      sq.push_back(s);
   endtask

   initial begin
      st_t s;
      forever begin
         @(posedge clk);
         #1;
         if (sq.size() > 0) begin
            s = sq.pop_front();
            check("q_a", int'(qa), s.q[0]);
            check("q_b", int'(qb), s.q[1]);
            check("wrap_a", int'(wa), int'(s.w[0]));
            check("wrap_b", int'(wb), int'(s.w[1]));
            check("load_err_a", int'(ea), int'(s.e[0]));
            check("load_err_b", int'(eb), int'(s.e[1]));
         end
      end
   end

   initial begin
      logic [1:0] t;
      forever begin
         @(negedge clk);
         #2;
         if (tq.size() > 0) begin
            t = tq.pop_front();
            check("tc_a", int'(tca), int'(t[0]));
            check("tc_b", int'(tcb), int'(t[1]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int hw, lw;
      rst = 1'b0; load = 1'b0; lv = '0; en = 1'b0; up_dn = 1'b1;
      c_rst = 1'b1; c_en = 1'b0;
      cyc(1, 0, 0, 0, 1);
      repeat (12) cyc(0, 0, 0, 1, 1);
      cyc(0, 1, 3, 0, 0);
      repeat (5) cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 12, 0, 1);
      cyc(0, 1, 4, 0, 1);
      repeat (3) cyc(0, 0, 0, 1, 1);
      cyc(0, 1, 9, 0, 1);
      cyc(0, 1, 5, 1, 1);
      cyc(1, 1, 7, 1, 1);
      cyc(0, 1, 7, 1, 0);
      repeat (3) cyc(0, 0, 0, 1, 1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      repeat (400)
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      cyc(0, 0, 0, 0, 1);
      repeat (3) @(negedge clk);
      check("drain", sq.size() + tq.size(), 0);
      if (!SAT) begin
         @(negedge clk);
         c_rst = 1'b1;
         @(negedge clk);
         c_rst = 1'b0;
         c_en = 1'b1;
         hw = 0;
         lw = 0;
         for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            check("casc_lo", int'(lo_q), n % 10);
            check("casc_hi", int'(hi_q), (n / 10) % 10);
            hw += int'(hi_w);
            lw += int'(lo_w);
         end
         check("casc_hi_wraps", hw, 1);
         check("casc_lo_wraps", lw, 10);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous modulo-N up/down counter, the general-purpose successor to the team's fixed 4-bit DFF up counter. It adds:
- configurable width and modulus;
- direction control, count enable and parallel load;
- a cascadable terminal-count output, a registered wrap pulse and a sticky load-error flag.

It sits wherever a divider, sequencer index or event counter is needed, and multiple instances chain via `tc` into `en`.

## Interface
Parameters:
- WIDTH, 4, counter bit width (≥ 1).
- MODULUS, 16, count range 0..MODULUS-1; legal 2..2^WIDTH.
- RESET_VALUE, 0, value of `q` after reset; must be < MODULUS.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational, for cascading).
- wrap  output  1  registered one-cycle wrap pulse.
- load_err  output  1  sticky flag: an out-of-range load occurred.

## Operation
Priority at each rising `clk` is rst > load > en > hold.
- **Reset:** `q`=RESET_VALUE, `wrap`=0, `load_err`=0.
- **Load:** if `load_val` < MODULUS, `q`=`load_val`.
  - Else `q`=MODULUS-1 and `load_err` is set to 1.
  - `load_err` stays 1 until `rst`.
  - `wrap`=0 on a load cycle.
  - `en` and `up_dn` are ignored on a load cycle.
- **Count up** (en=1, up_dn=1):
  - If `q`=MODULUS-1, then `q`=0 and `wrap`=1 next cycle.
  - Else `q`=q+1.
- **Count down** (en=1, up_dn=0):
  - If `q`=0, then `q`=MODULUS-1 and `wrap`=1 next cycle.
  - Else `q`=q-1.
- **Hold** (en=0): `q` unchanged, `wrap`=0.
- **tc** = en & ~load & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)).
  - It is purely combinational from current inputs and `q`.
  - It is high exactly in the cycle whose edge will wrap.
- **Arithmetic:**
  - Compares and the next-state calculation use WIDTH+1 bits internally, so MODULUS=2^WIDTH needs no special case.
  - `q` never holds a value ≥ MODULUS.
- **Direction change** takes effect on the next edge, with no dead cycle. A change in the same cycle as a wrap uses the new `up_dn`.

## Timing
- Latency: inputs sampled at edge N are visible on `q` after edge N.
- `wrap` asserts in the same cycle as the wrapped value on `q`. It lasts exactly one cycle per wrap event.
- With `en` held high continuously, `wrap` pulses once every MODULUS cycles in either direction.
- `tc` has a combinational path from `en`, `load` and `up_dn` to the output. Cascade `tc` of stage k into `en` of stage k+1, with the same `clk`, `rst` and `up_dn`.
- **Reset mid-count:** overrides load and en in that cycle. `q`=RESET_VALUE and `wrap`=0 on the next cycle, and `tc` follows from the new `q`.
- **Load in a terminal-count cycle:** `tc`=0 and no wrap occurs.

## Configuration
- Macro `UDCNT_SAT_EN`.
- **Defined:** saturating mode.
  - Counting up at MODULUS-1 holds at MODULUS-1; counting down at 0 holds at 0.
  - `wrap` is tied to 0.
  - `tc` is unchanged: it still flags the terminal value, so a saturated counter can stall a cascade.
  - Load and reset behave the same as in wrapping mode.
- **Undefined (default):** modulo wrapping as described in Operation.

## Test plan
WIDTH=4, MODULUS=10, RESET_VALUE=0 unless stated.
1. Reset then en=1, up_dn=1 for 12 cycles.
   - `q` = 0..9,0,1,2.
   - `wrap`=1 only in the cycle `q`=0 after 9.
   - `tc`=1 only while `q`=9.
2. Load 3, then en=1, up_dn=0 for 5 cycles.
   - `q` = 3,2,1,0,9,8.
   - `wrap`=1 in the cycle `q`=9.
   - `tc`=1 while `q`=0.
3. Load 12 (out of range).
   - `q`=9 and `load_err`=1.
   - `load_err` stays 1 after further valid loads and counting; it clears only on `rst`.
4. Simultaneous events.
   - `q`=9 with en=1, up_dn=1, load=1, load_val=5: `q`=5, `wrap`=0, `tc`=0 in that cycle.
   - Next cycle, rst=1 together with load=1: `q`=0.
5. Cascade two instances (MODULUS=10 each) with en held high for 100 cycles.
   - Low digit cycles 0..9.
   - High digit increments once per low-digit wrap.
   - After 100 cycles both digits = 0, and the high stage shows `wrap`=1 once.
6. With `UDCNT_SAT_EN`:
   - Up from 7 for 5 cycles: `q` = 8,9,9,9,9, `wrap` never set, `tc`=1 from `q`=9 onward.
   - Down from 1: `q` = 0,0.
